// File: rtl/uart_rx_fifo_if.sv
// Serial line, runtime configuration and host-side FIFO signals of the receiver.
interface uart_rx_fifo_if #(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 8,
    parameter int PERIOD_W   = 14
);
    logic                          serial_in;
    logic [PERIOD_W-1:0]           bit_period;
    logic [3:0]                    data_size;
    logic [1:0]                    parity_mode;
    logic                          stop_bits;
    logic                          data_read;
    logic                          clear_errors;
    logic [DATA_W-1:0]             rx_data;
    logic                          rx_valid;
    logic                          parity_error;
    logic                          framing_error;
    logic                          overrun_error;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    // Host / line side: drives the line, configuration and pops.
    modport master (
        output serial_in, bit_period, data_size, parity_mode, stop_bits,
               data_read, clear_errors,
        input  rx_data, rx_valid, parity_error, framing_error,
               overrun_error, fifo_count
    );

    // Receiver side.
    modport slave (
        input  serial_in, bit_period, data_size, parity_mode, stop_bits,
               data_read, clear_errors,
        output rx_data, rx_valid, parity_error, framing_error,
               overrun_error, fifo_count
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Configurable UART receiver with majority-vote sampling, false-start
// rejection and a first-word fall-through receive FIFO carrying per-entry
// parity/framing flags.
module uart_rx_fifo #(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 8,
    parameter int PERIOD_W   = 14
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] MAX_SIZE = 4'(DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PUSH, WAIT_IDLE} state_t;

    state_t              state_q, state_d;
    logic                sync1_q, s_in, h0_q, h1_q;
    logic [PERIOD_W-1:0] period_q, phase_q, period_n;
    logic [3:0]          size_q, size_n, bit_q;
    logic                par_en_q, par_odd_q, stop2_q, stop_cnt_q;
    logic [DATA_W-1:0]   data_q;
    logic                perr_q, ferr_q;
    logic                start_det, sample_now, maj;

    logic [DATA_W+1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wptr_q, rptr_q;
    logic [CW-1:0]       count_q;
    logic                ovr_q, full, push_req, do_push, do_pop;
    logic [DATA_W+1:0]   head;

    // Two-flop synchroniser plus two cycles of history for the majority vote.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            s_in    <= 1'b1;
            h0_q    <= 1'b1;
            h1_q    <= 1'b1;
        end else begin
            sync1_q <= bus.serial_in;
            s_in    <= sync1_q;
            h0_q    <= s_in;
            h1_q    <= h0_q;
        end
    end

    // Start edge, sample strobe, vote and clamped configuration.
    always_comb begin
        start_det  = (state_q == IDLE) && h0_q && !s_in;
        sample_now = (phase_q == ((period_q >> 1) + PERIOD_W'(1)));
        maj        = (h1_q & h0_q) | (h1_q & s_in) | (h0_q & s_in);
        period_n   = (bus.bit_period < PERIOD_W'(4)) ? PERIOD_W'(4) : bus.bit_period;
        size_n     = bus.data_size;
        if (bus.data_size < 4'd5)
            size_n = 4'd5;
        else if (bus.data_size > MAX_SIZE)
            size_n = MAX_SIZE;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic; decisions land one cycle after the centre sample.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_det) state_d = START;
            START:     if (sample_now) state_d = maj ? IDLE : DATA;
            DATA:      if (sample_now && (bit_q == size_q - 4'd1))
                           state_d = par_en_q ? PARITY : STOP;
            PARITY:    if (sample_now) state_d = STOP;
            STOP:      if (sample_now && (!stop2_q || stop_cnt_q)) state_d = PUSH;
            PUSH:      state_d = ferr_q ? WAIT_IDLE : IDLE;
            WAIT_IDLE: if (s_in) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Frame datapath: config latch, bit timer and sampled bit accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q   <= PERIOD_W'(4);
            phase_q    <= '0;
            size_q     <= 4'd5;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            bit_q      <= '0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else if (start_det) begin
            period_q   <= period_n;
            phase_q    <= PERIOD_W'(1);
            size_q     <= size_n;
            par_en_q   <= (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
            par_odd_q  <= (bus.parity_mode == 2'b10);
            stop2_q    <= bus.stop_bits;
            stop_cnt_q <= 1'b0;
            bit_q      <= '0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            phase_q <= (phase_q >= period_q - PERIOD_W'(1)) ? '0 : phase_q + PERIOD_W'(1);
            if (sample_now) begin
                case (state_q)
                    DATA: begin
                        data_q[bit_q] <= maj;
                        bit_q         <= bit_q + 4'd1;
                    end
                    PARITY: perr_q <= ((^data_q) ^ maj) != par_odd_q;
                    STOP: begin
                        if (!maj) ferr_q <= 1'b1;
                        stop_cnt_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // FIFO control: push+pop on a full FIFO succeeds, push alone drops the frame.
    always_comb begin
        push_req = (state_q == PUSH);
        full     = (count_q == CW'(FIFO_DEPTH));
        do_pop   = bus.data_read && (count_q != '0);
        do_push  = push_req && (!full || do_pop);
        head     = mem[rptr_q];
    end

    // FIFO storage (no reset needed; outputs are masked while empty).
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= {data_q, perr_q, ferr_q};
    end

    // FIFO pointers, occupancy and sticky overrun (set wins over clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
            if (push_req && full && !do_pop) ovr_q <= 1'b1;
            else if (bus.clear_errors)       ovr_q <= 1'b0;
        end
    end

    // Head-of-FIFO outputs, zero while empty.
    always_comb begin
        bus.rx_valid      = (count_q != '0);
        bus.rx_data       = bus.rx_valid ? head[DATA_W+1:2] : '0;
        bus.parity_error  = bus.rx_valid & head[1];
        bus.framing_error = bus.rx_valid & head[0];
        bus.overrun_error = ovr_q;
        bus.fifo_count    = count_q;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (FIFO_DEPTH = 4).
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   P = 10;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_W(9), .FIFO_DEPTH(4), .PERIOD_W(14)) bus ();
    uart_rx_fifo #(.DATA_W(9), .FIFO_DEPTH(4), .PERIOD_W(14)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int per, input logic [3:0] sz, input logic [1:0] pm, input logic sb);
        P = per;
        bus.bit_period  = 14'(per);
        bus.data_size   = sz;
        bus.parity_mode = pm;
        bus.stop_bits   = sb;
    endtask

    // Drive a frame one clock at a time; gbit selects a bit whose centre
    // clock is inverted (-1 for none). Ends with two idle bit periods.
    task automatic send_frame(input logic [8:0] d, input int n, input int has_par,
                              input logic pbit, input int nstop, input logic s1,
                              input logic s2, input int gbit);
        logic [15:0] b;
        int idx;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < n; i++) b[1+i] = d[i];
        idx = 1 + n;
        if (has_par != 0) begin b[idx] = pbit; idx++; end
        b[idx] = s1; idx++;
        if (nstop == 2) begin b[idx] = s2; idx++; end
        for (int j = 0; j < idx; j++)
            for (int c = 0; c < P; c++) begin
                tick();
                bus.serial_in = (j == gbit && c == P / 2) ? ~b[j] : b[j];
            end
        for (int c = 0; c < 2 * P; c++) begin
            tick();
            bus.serial_in = 1'b1;
        end
    endtask

    task automatic pop();
        tick();
        bus.data_read = 1'b1;
        tick();
        bus.data_read = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.serial_in = 1'b1;
        bus.data_read = 1'b0;
        bus.clear_errors = 1'b0;
        set_cfg(10, 4'd8, 2'b00, 1'b0);
        repeat (4) tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.rx_valid); end
        checks++; if (bus.rx_data !== 9'h000) begin failures++; $display("FAIL reset_data got=%h exp=000", bus.rx_data); end
        checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.fifo_count); end
        checks++; if ({bus.parity_error, bus.framing_error, bus.overrun_error} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {bus.parity_error, bus.framing_error, bus.overrun_error}); end
    endtask

    task automatic test_basic();
        set_cfg(10, 4'd8, 2'b00, 1'b0);
        send_frame(9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1);
        checks++; if (bus.rx_data !== 9'h0A5) begin failures++; $display("FAIL basic_data got=%h exp=0a5", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.rx_valid); end
        checks++; if (bus.fifo_count !== 3'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", bus.fifo_count); end
        checks++; if ({bus.parity_error, bus.framing_error, bus.overrun_error} !== 3'b000) begin
            failures++; $display("FAIL basic_flags got=%b exp=000", {bus.parity_error, bus.framing_error, bus.overrun_error}); end
        pop();
        checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL basic_pop_valid got=%b exp=0", bus.rx_valid); end
        checks++; if (bus.rx_data !== 9'h000) begin failures++; $display("FAIL basic_pop_data got=%h exp=000", bus.rx_data); end
    endtask

    task automatic test_parity();
        // 0x35 has four ones: even parity bit should be 0, so 1 is an error.
        set_cfg(10, 4'd7, 2'b01, 1'b0);
        send_frame(9'h035, 7, 1, 1'b1, 1, 1'b1, 1'b1, -1);
        checks++; if (bus.parity_error !== 1'b1) begin failures++; $display("FAIL par_even_err got=%b exp=1", bus.parity_error); end
        checks++; if (bus.rx_data !== 9'h035) begin failures++; $display("FAIL par_even_data got=%h exp=035", bus.rx_data); end
        pop();
        set_cfg(10, 4'd7, 2'b10, 1'b0);
        send_frame(9'h035, 7, 1, 1'b1, 1, 1'b1, 1'b1, -1);
        checks++; if (bus.parity_error !== 1'b0) begin failures++; $display("FAIL par_odd_err got=%b exp=0", bus.parity_error); end
        checks++; if (bus.rx_data !== 9'h035) begin failures++; $display("FAIL par_odd_data got=%h exp=035", bus.rx_data); end
        checks++; if (bus.framing_error !== 1'b0) begin failures++; $display("FAIL par_odd_ferr got=%b exp=0", bus.framing_error); end
        pop();
    endtask

    task automatic test_break();
        set_cfg(10, 4'd8, 2'b00, 1'b0);
        tick();
        bus.serial_in = 1'b0;
        repeat (30 * 10) tick();
        checks++; if (bus.fifo_count !== 3'd1) begin failures++; $display("FAIL brk_count got=%0d exp=1", bus.fifo_count); end
        checks++; if (bus.rx_data !== 9'h000 || bus.rx_valid !== 1'b1) begin
            failures++; $display("FAIL brk_data got=%h/%b exp=000/1", bus.rx_data, bus.rx_valid); end
        checks++; if (bus.framing_error !== 1'b1) begin failures++; $display("FAIL brk_ferr got=%b exp=1", bus.framing_error); end
        bus.serial_in = 1'b1;
        repeat (30) tick();
        checks++; if (bus.fifo_count !== 3'd1) begin failures++; $display("FAIL brk_release_count got=%0d exp=1", bus.fifo_count); end
        pop();
        send_frame(9'h05A, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1);
        checks++; if (bus.rx_data !== 9'h05A || bus.framing_error !== 1'b0) begin
            failures++; $display("FAIL brk_next got=%h/%b exp=05a/0", bus.rx_data, bus.framing_error); end
        pop();
    endtask

    task automatic test_overrun();
        logic [8:0] exp_q [4];
        set_cfg(10, 4'd8, 2'b00, 1'b0);
        exp_q[0] = 9'h011; exp_q[1] = 9'h022; exp_q[2] = 9'h033; exp_q[3] = 9'h044;
        for (int i = 0; i < 4; i++) send_frame(exp_q[i], 8, 0, 1'b0, 1, 1'b1, 1'b1, -1);
        checks++; if (bus.overrun_error !== 1'b0) begin failures++; $display("FAIL ovr_before got=%b exp=0", bus.overrun_error); end
        send_frame(9'h055, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1);
        checks++; if (bus.fifo_count !== 3'd4) begin failures++; $display("FAIL ovr_count got=%0d exp=4", bus.fifo_count); end
        checks++; if (bus.overrun_error !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", bus.overrun_error); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.rx_data !== exp_q[i]) begin failures++; $display("FAIL ovr_read%0d got=%h exp=%h", i, bus.rx_data, exp_q[i]); end
            pop();
        end
        checks++; if (bus.fifo_count !== 3'd0 || bus.overrun_error !== 1'b1) begin
            failures++; $display("FAIL ovr_sticky got=%0d/%b exp=0/1", bus.fifo_count, bus.overrun_error); end
        tick(); bus.clear_errors = 1'b1;
        tick(); bus.clear_errors = 1'b0;
        checks++; if (bus.overrun_error !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", bus.overrun_error); end

        // Full FIFO, pop exactly on the PUSH cycle: start bit driven after
        // edge E0, line reaches s_in at E2, PUSH occupies [E99,E100).
        exp_q[0] = 9'h002; exp_q[1] = 9'h003; exp_q[2] = 9'h004; exp_q[3] = 9'h055;
        send_frame(9'h001, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1);
        for (int i = 0; i < 3; i++) send_frame(exp_q[i], 8, 0, 1'b0, 1, 1'b1, 1'b1, -1);
        fork
            send_frame(9'h055, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1);
            begin
                repeat (100) tick();
                bus.data_read = 1'b1;
                tick();
                bus.data_read = 1'b0;
            end
        join
        checks++; if (bus.fifo_count !== 3'd4 || bus.overrun_error !== 1'b0) begin
            failures++; $display("FAIL simul_state got=%0d/%b exp=4/0", bus.fifo_count, bus.overrun_error); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.rx_data !== exp_q[i]) begin failures++; $display("FAIL simul_read%0d got=%h exp=%h", i, bus.rx_data, exp_q[i]); end
            pop();
        end
    endtask

    task automatic test_false_start();
        set_cfg(16, 4'd8, 2'b00, 1'b0);
        tick(); bus.serial_in = 1'b0;
        repeat (3) tick();
        bus.serial_in = 1'b1;
        repeat (3 * 16) tick();
        checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL fs_count got=%0d exp=0", bus.fifo_count); end
        send_frame(9'h03C, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1);
        checks++; if (bus.rx_data !== 9'h03C || bus.fifo_count !== 3'd1) begin
            failures++; $display("FAIL fs_next got=%h/%0d exp=03c/1", bus.rx_data, bus.fifo_count); end
        pop();
        // Bit index 3 of the frame is data bit 2 (a one) of 0x3C.
        send_frame(9'h03C, 8, 0, 1'b0, 1, 1'b1, 1'b1, 3);
        checks++; if (bus.rx_data !== 9'h03C || bus.fifo_count !== 3'd1) begin
            failures++; $display("FAIL glitch got=%h/%0d exp=03c/1", bus.rx_data, bus.fifo_count); end
        pop();
    endtask

    task automatic test_max_and_reset();
        // 0x1A7 has six ones, so the odd parity bit is 1.
        set_cfg(10, 4'd9, 2'b10, 1'b1);
        send_frame(9'h1A7, 9, 1, 1'b1, 2, 1'b1, 1'b1, -1);
        checks++; if (bus.rx_data !== 9'h1A7) begin failures++; $display("FAIL max_data got=%h exp=1a7", bus.rx_data); end
        checks++; if ({bus.parity_error, bus.framing_error} !== 2'b00) begin
            failures++; $display("FAIL max_flags got=%b exp=00", {bus.parity_error, bus.framing_error}); end
        pop();
        send_frame(9'h1A7, 9, 1, 1'b1, 2, 1'b1, 1'b0, -1);
        checks++; if (bus.framing_error !== 1'b1 || bus.rx_data !== 9'h1A7) begin
            failures++; $display("FAIL max_stop2 got=%b/%h exp=1/1a7", bus.framing_error, bus.rx_data); end
        checks++; if (bus.parity_error !== 1'b0) begin failures++; $display("FAIL max_stop2_perr got=%b exp=0", bus.parity_error); end
        pop();
        send_frame(9'h1A7, 9, 1, 1'b1, 2, 1'b1, 1'b1, -1);
        tick(); bus.serial_in = 1'b0;
        repeat (25) tick();
        rst = 1'b1;
        bus.serial_in = 1'b1;
        #1;
        checks++; if (bus.rx_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.rx_data !== 9'h000) begin
            failures++; $display("FAIL rst_mid got=%b/%0d/%h exp=0/0/000", bus.rx_valid, bus.fifo_count, bus.rx_data); end
        repeat (2) tick();
        rst = 1'b0;
        repeat (30) tick();
        checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL rst_no_entry got=%0d exp=0", bus.fifo_count); end
        send_frame(9'h0F3, 9, 1, 1'b1, 2, 1'b1, 1'b1, -1);
        checks++; if (bus.rx_data !== 9'h0F3 || bus.parity_error !== 1'b0) begin
            failures++; $display("FAIL rst_next got=%h/%b exp=0f3/0", bus.rx_data, bus.parity_error); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_break();
        test_overrun();
        test_false_start();
        test_max_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
